pc_fetch: RTL and testbench

//  Program-counter register and instruction-fetch sequencer; sits directly downstream of the

---
 rtl/pc_fetch.sv | 141 ++++++++++++++
 tb/tb_pc_fetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// ----------------------------------------------------------------------------
// pc_fetch
//   Program-counter register and instruction-fetch sequencer. Holds the PC,
//   fetches the word at PC over a req/ready handshake, presents it to
//   execute for at least one cycle, then takes the next PC from the
//   jump/branch logic. A misaligned next PC or a fetch that waits too long
//   drops the sequencer into a terminal error state until reset.
//
//   Ports
//     clk, rst_n       clock (rising edge) / asynchronous active-low reset
//     next_pc          next PC from jump/branch logic, taken in EXEC
//     stall            hold the current instruction in EXEC
//     imem_req         fetch request, high throughout FETCH
//     imem_addr        fetch address (= pc)
//     imem_ready       memory response strobe for imem_rdata
//     imem_rdata       fetched instruction word
//     pc               address of the instruction in id
//     ia               fall-through address, kernel bit pc[31] preserved
//     id               current instruction word
//     instr_valid      id valid for execute/commit (EXEC only)
//     fetch_err        sticky error flag, cleared only by reset
//     badaddr          address that caused fetch_err
// ----------------------------------------------------------------------------
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ia,
  output logic [31:0] id,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [31:0] badaddr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  // Counter only needs to reach TIMEOUT-1; keep at least one bit so the
  // design still elaborates when the timeout is disabled.
  localparam int unsigned CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam bit          TO_EN     = (TIMEOUT != 0);

  state_e        state_q,   state_d;
  logic [31:0]   pc_q,      pc_d;
  logic [31:0]   id_q,      id_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          err_q,     err_d;
  logic [31:0]   badaddr_q, badaddr_d;

  // Next-state and datapath update for the fetch sequencer.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    badaddr_d = badaddr_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          id_d    = imem_rdata;
          cnt_d   = {CW{1'b0}};
          state_d = S_EXEC;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          // TIMEOUT cycles spent in FETCH without a response.
          err_d     = 1'b1;
          badaddr_d = pc_q;
          cnt_d     = {CW{1'b0}};
          state_d   = S_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EXEC: begin
        if (stall) begin
          state_d = S_EXEC;
        end else if (next_pc[1:0] != 2'b00) begin
          err_d     = 1'b1;
          badaddr_d = next_pc;
          state_d   = S_ERR;
        end else begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      id_q      <= 32'h0000_0000;
      cnt_q     <= {CW{1'b0}};
      err_q     <= 1'b0;
      badaddr_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      badaddr_q <= badaddr_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_EXEC);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign id          = id_q;
  assign fetch_err   = err_q;
  assign badaddr     = badaddr_q;
  // 31-bit increment; carry out of bit 30 is dropped, kernel bit passes.
  assign ia          = {pc_q[31], pc_q[30:0] + 31'd4};

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int unsigned TO  = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ia;
  logic [31:0] id;
  logic        instr_valid;
  logic        fetch_err;
  logic [31:0] badaddr;

  pc_fetch #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc(pc), .ia(ia), .id(id),
    .instr_valid(instr_valid), .fetch_err(fetch_err), .badaddr(badaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] id;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  logic [31:0] last_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Fall-through address from the architectural rule: pc+4 within the low
  // 31 bits, kernel bit kept as is.
  function automatic logic [31:0] model_ia(input logic [31:0] p);
    return (p & 32'h8000_0000) | ((p + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  // Monitor: every new EXEC entry consumes one expected instruction and the
  // whole EXEC window (including stalls) must show that instruction.
  logic mon_prev = 1'b0;
  exp_t cur;
  bit   have_cur = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev = 1'b0;
    end else begin
      if (instr_valid && !mon_prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual=instr_valid required=no_instruction pc=%h", pc);
          have_cur = 1'b0;
        end else begin
          cur      = sb_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (instr_valid && have_cur) begin
        chk("exec_pc", pc, cur.pc);
        chk("exec_id", id, cur.id);
        chk("exec_ia", ia, model_ia(cur.pc));
      end
      mon_prev = instr_valid;
    end
  end

  task automatic wait_req(output int n);
    n = 0;
    while (imem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Serve one fetch: d wait cycles then ready with rdata.
  task automatic do_fetch(input logic [31:0] rdata, input int d, input int exp_wait);
    int n;
    wait_req(n);
    chk("req_latency", 32'(n), 32'(exp_wait));
    chk("imem_addr", imem_addr, exp_pc);
    sb_q.push_back('{pc: exp_pc, id: rdata});
    last_id = rdata;
    for (int k = 0; k <= d; k++) begin
      stall   = 1'($urandom);
      next_pc = $urandom;
      if (k < d) begin
        imem_ready = 1'b0;
        imem_rdata = $urandom;
      end else begin
        imem_ready = 1'b1;
        imem_rdata = rdata;
      end
      @(negedge clk);
      if (k < d) begin
        chk("req_hold", {31'd0, imem_req}, 32'd1);
        chk("addr_hold", imem_addr, exp_pc);
      end else begin
        chk("req_drop", {31'd0, imem_req}, 32'd0);
      end
    end
    // Responses outside FETCH must be ignored.
    imem_ready = 1'($urandom);
    imem_rdata = $urandom;
  endtask

  // Hold EXEC for s stall cycles, then hand over npc.
  task automatic do_exec(input int s, input logic [31:0] npc);
    for (int j = 0; j < s; j++) begin
      stall   = 1'b1;
      next_pc = $urandom;
      @(negedge clk);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    stall   = 1'b0;
    next_pc = npc;
    exp_pc  = npc;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] saved_pc;
    int          n;
    int          cnt;
    int          d;
    int          s;
    logic [31:0] npc;

    rst_n      = 1'b0;
    next_pc    = 32'h0;
    stall      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    exp_pc     = RPC;
    last_id    = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, RPC);
    chk("rst_ia", ia, RPC + 32'd4);
    chk("rst_id", id, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_badaddr", badaddr, 32'h0);
    rst_n = 1'b1;

    // Directed: delayed ready on the last permitted cycle, stalls, ia wrap
    // cases and a self-loop.
    do_fetch(32'h2008_0005, 3, 1);
    do_exec(2, 32'h0000_0200);
    do_fetch($urandom, 0, 0);
    do_exec(0, 32'h7FFF_FFFC);
    do_fetch($urandom, 1, 0);
    do_exec(1, 32'hFFFF_FFFC);
    do_fetch($urandom, 0, 0);
    do_exec(0, 32'hFFFF_FFFC);
    do_fetch($urandom, 2, 0);
    do_exec(0, 32'h0000_1000);

    // Random instruction stream.
    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, 3);
      do_fetch($urandom, d, 0);
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      npc = ($urandom_range(0, 7) == 0) ? exp_pc : ($urandom & 32'hFFFF_FFFC);
      do_exec(s, npc);
    end

    // Misaligned next PC.
    do_fetch($urandom, 0, 0);
    saved_pc = exp_pc;
    stall    = 1'b0;
    next_pc  = 32'h0000_0202;
    @(negedge clk);
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_badaddr", badaddr, 32'h0000_0202);
    chk("mis_pc", pc, saved_pc);
    for (int k = 0; k < 3; k++) begin
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      next_pc    = $urandom & 32'hFFFF_FFFC;
      @(negedge clk);
      chk("err_req", {31'd0, imem_req}, 32'd0);
      chk("err_valid", {31'd0, instr_valid}, 32'd0);
      chk("err_pc", pc, saved_pc);
      chk("err_id", id, last_id);
      chk("err_sticky", {31'd0, fetch_err}, 32'd1);
    end

    // Reset clears the sticky error; then a fetch that never completes.
    imem_ready = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("rst2_err", {31'd0, fetch_err}, 32'd0);
    chk("rst2_badaddr", badaddr, 32'h0);
    chk("rst2_pc", pc, RPC);
    @(negedge clk);
    rst_n = 1'b1;
    wait_req(n);
    chk("to_latency", 32'(n), 32'd1);
    cnt = 0;
    while (imem_req === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("to_cycles", 32'(cnt), 32'(TO));
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_badaddr", badaddr, RPC);
    chk("to_valid", {31'd0, instr_valid}, 32'd0);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("to_id_frozen", id, 32'h0);
    chk("to_req", {31'd0, imem_req}, 32'd0);

    // Asynchronous reset in the middle of a fetch.
    imem_ready = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    exp_pc = RPC;
    do_fetch($urandom, 0, 1);
    do_exec(0, 32'hFFFF_FFFC);
    imem_ready = 1'b0;
    chk("pre_abort_addr", imem_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_req", {31'd0, imem_req}, 32'd0);
    chk("abort_pc", pc, RPC);
    chk("abort_ia", ia, RPC + 32'd4);
    chk("abort_valid", {31'd0, instr_valid}, 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
